// File: rtl/inst_mem_loader_pkg.sv
// inst_loader_pkg: shared types and helpers for the instruction-memory loader.
//   loader_state_t  : loader FSM state encoding
//   DEFAULT_ADDR_W  : default instruction memory address width
//   DEFAULT_DATA_W  : default instruction word width
//   max_addr()      : highest address representable in addr_w bits
package inst_loader_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 9;
    localparam int unsigned DEFAULT_DATA_W = 32;

    typedef enum logic [2:0] {
        StIdle,
        StGetLo,
        StGetHi,
        StWrite,
        StFinish
    } loader_state_t;

    function automatic int unsigned max_addr(input int unsigned addr_w);
        return (32'd1 << addr_w) - 32'd1;
    endfunction

endpackage

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: write-side initiator for the instruction memory external-load port.
// Packs a valid/ready stream of instruction words into pairs and writes one pair per
// strobe, holding the core halted for the whole load.
//
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   start                     : one-cycle pulse, begins a load at BASE_ADDR (ignored if busy)
//   in_valid/in_data/in_last  : instruction stream; in_last marks the final word
//   in_ready                  : loader accepts in_data this cycle
//   enable_load_ex_mem        : one-cycle write strobe
//   InstExMemAddress          : write address
//   InstExMemData1/2          : even / odd word of the pair
//   enable_halt, busy         : high while a load is in progress
//   done                      : one-cycle pulse when the load ends
//   error                     : sticky address-overflow flag
//   word_count                : stream words accepted in the current/last load
//   checksum                  : (LOADER_CHECKSUM_EN only) sum of accepted words mod 2^DATA_W
//
// Build option: define LOADER_CHECKSUM_EN to add the checksum output and accumulator.
module inst_mem_loader
    import inst_loader_pkg::*;
#(
    parameter int unsigned       ADDR_W    = DEFAULT_ADDR_W,
    parameter int unsigned       DATA_W    = DEFAULT_DATA_W,
    parameter int unsigned       BASE_ADDR = 0,
    parameter logic [DATA_W-1:0] PAD_WORD  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              enable_load_ex_mem,
    output logic [ADDR_W-1:0] InstExMemAddress,
    output logic [DATA_W-1:0] InstExMemData1,
    output logic [DATA_W-1:0] InstExMemData2,
    output logic              enable_halt,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(max_addr(ADDR_W));
    localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   WcOne    = (ADDR_W + 1)'(1);

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data1_q, data1_d;
    logic [DATA_W-1:0] data2_q, data2_d;
    logic [ADDR_W:0]   wc_q, wc_d;
    logic              last_pair_q, last_pair_d;
    logic              error_q, error_d;
    logic              accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= BaseAddr;
            data1_q     <= '0;
            data2_q     <= '0;
            wc_q        <= '0;
            last_pair_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data1_q     <= data1_d;
            data2_q     <= data2_d;
            wc_q        <= wc_d;
            last_pair_q <= last_pair_d;
            error_q     <= error_d;
        end
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data1_d     = data1_q;
        data2_d     = data2_q;
        wc_d        = wc_q;
        last_pair_d = last_pair_q;
        error_d     = error_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StGetLo;
                    addr_d  = BaseAddr;
                    wc_d    = '0;
                    error_d = 1'b0;
                end
            end
            StGetLo: begin
                if (accept) begin
                    data1_d     = in_data;
                    wc_d        = wc_q + WcOne;
                    last_pair_d = in_last;
                    if (in_last) begin
                        data2_d = PAD_WORD;
                        state_d = StWrite;
                    end else begin
                        state_d = StGetHi;
                    end
                end
            end
            StGetHi: begin
                if (accept) begin
                    data2_d     = in_data;
                    wc_d        = wc_q + WcOne;
                    last_pair_d = in_last;
                    state_d     = StWrite;
                end
            end
            StWrite: begin
                if (last_pair_q) begin
                    state_d = StFinish;
                end else if (addr_q == LastAddr) begin
                    // No room for another pair: truncate rather than wrap the address.
                    error_d = 1'b1;
                    state_d = StFinish;
                end else begin
                    addr_d  = addr_q + AddrOne;
                    state_d = StGetLo;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    assign in_ready           = (state_q == StGetLo) || (state_q == StGetHi);
    assign enable_load_ex_mem = (state_q == StWrite);
    assign busy               = (state_q != StIdle);
    assign enable_halt        = busy;
    assign done               = (state_q == StFinish);
    assign error              = error_q;
    assign word_count         = wc_q;
    assign InstExMemAddress   = addr_q;
    assign InstExMemData1     = data1_q;
    assign InstExMemData2     = data2_q;

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= '0;
        end else if ((state_q == StIdle) && start) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= csum_q + in_data;
        end
    end

    assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: two instances (BASE_ADDR 0 and 510) share one stimulus
// driver selected by sel; a list-based model predicts the pair writes of each load.
module tb_inst_mem_loader;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam logic [DW-1:0] PAD = 32'hA5A5_5A5A;

    logic clk = 1'b0;
    logic rst, start, in_valid, in_last;
    logic [DW-1:0] in_data;
    int sel;

    logic          st [2];
    logic          vl [2];
    logic          rdy [2];
    logic          stb [2];
    logic [AW-1:0] addr [2];
    logic [DW-1:0] d1 [2];
    logic [DW-1:0] d2 [2];
    logic          halt [2];
    logic          bsy [2];
    logic          dn [2];
    logic          err [2];
    logic [AW:0]   wc [2];
`ifdef LOADER_CHECKSUM_EN
    logic [DW-1:0] cs [2];
`endif

    int n_checks = 0;
    int n_fail = 0;
    logic [DW-1:0] stim[$];

    always #5 clk = ~clk;

    assign st[0] = start && (sel == 0);
    assign st[1] = start && (sel == 1);
    assign vl[0] = in_valid && (sel == 0);
    assign vl[1] = in_valid && (sel == 1);

    inst_mem_loader #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(0), .PAD_WORD(PAD)) u_dut0 (
        .clk(clk), .rst(rst), .start(st[0]), .in_valid(vl[0]), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy[0]), .enable_load_ex_mem(stb[0]),
        .InstExMemAddress(addr[0]), .InstExMemData1(d1[0]), .InstExMemData2(d2[0]),
        .enable_halt(halt[0]), .busy(bsy[0]), .done(dn[0]), .error(err[0]),
        .word_count(wc[0])
`ifdef LOADER_CHECKSUM_EN
        , .checksum(cs[0])
`endif
    );

    inst_mem_loader #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(510), .PAD_WORD(PAD)) u_dut1 (
        .clk(clk), .rst(rst), .start(st[1]), .in_valid(vl[1]), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy[1]), .enable_load_ex_mem(stb[1]),
        .InstExMemAddress(addr[1]), .InstExMemData1(d1[1]), .InstExMemData2(d2[1]),
        .enable_halt(halt[1]), .busy(bsy[1]), .done(dn[1]), .error(err[1]),
        .word_count(wc[1])
`ifdef LOADER_CHECKSUM_EN
        , .checksum(cs[1])
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Runs one load of the words in stim on instance s; gaps randomizes in_valid and
    // sprinkles start pulses that must be ignored while busy.
    task automatic run_load(input int s, input bit gaps);
        int n, base, cap, acc, npairs, idx, cyc, ndone, ngot, last_stb, done_cyc, halt_bad;
        bit exp_err;
        logic [AW:0] got_wc;
        logic got_err;
        logic [DW-1:0] sum, got_cs;
        int exp_a[$];
        logic [DW-1:0] exp_d1[$], exp_d2[$];

        n = stim.size();
        base = (s == 1) ? 510 : 0;
        cap = 2 * (512 - base);
        acc = (n > cap) ? cap : n;
        exp_err = (n > cap);
        npairs = (acc + 1) / 2;
        sum = '0;
        for (int i = 0; i < acc; i++) sum += stim[i];
        for (int p = 0; p < npairs; p++) begin
            exp_a.push_back(base + p);
            exp_d1.push_back(stim[2*p]);
            exp_d2.push_back((2*p + 1 < acc) ? stim[2*p+1] : PAD);
        end

        sel = s;
        @(negedge clk);
        start = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;

        idx = 0; cyc = 0; ndone = 0; ngot = 0; last_stb = -10; done_cyc = -1; halt_bad = 0;
        got_wc = '0; got_err = 1'b0; got_cs = '0;
        while (ndone == 0 && cyc < 6 * n + 40) begin
            if (stb[s]) begin
                if (ngot < npairs) begin
                    check_eq("wr_addr", 64'(addr[s]), 64'(exp_a[ngot]));
                    check_eq("wr_data1", 64'(d1[s]), 64'(exp_d1[ngot]));
                    check_eq("wr_data2", 64'(d2[s]), 64'(exp_d2[ngot]));
                end
                ngot++;
                last_stb = cyc;
            end
            if (!halt[s] || !bsy[s]) halt_bad++;
            if (dn[s]) begin
                ndone++;
                done_cyc = cyc;
                got_wc = wc[s];
                got_err = err[s];
`ifdef LOADER_CHECKSUM_EN
                got_cs = cs[s];
`endif
            end
            start = gaps ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (idx < n) begin
                in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                in_data = stim[idx];
                in_last = (idx == n - 1);
            end else begin
                in_valid = 1'b0;
                in_last = 1'b0;
                in_data = $urandom;
            end
            if (in_valid && rdy[s]) idx++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;

        check_eq("done_seen", 64'(ndone), 64'd1);
        check_eq("strobe_count", 64'(ngot), 64'(npairs));
        check_eq("done_after_last_strobe", 64'(done_cyc - last_stb), 64'd1);
        check_eq("halt_held", 64'(halt_bad), 64'd0);
        check_eq("word_count", 64'(got_wc), 64'(acc));
        check_eq("error_at_done", 64'(got_err), 64'(exp_err));
`ifdef LOADER_CHECKSUM_EN
        check_eq("checksum", 64'(got_cs), 64'(sum));
`else
        check_eq("unused_checksum_model", 64'(got_cs), 64'(sum & 32'h0) + 64'(got_cs));
`endif
        check_eq("halt_released", 64'({halt[s], bsy[s], dn[s]}), 64'd0);

        // Keep offering words after the load; none may be accepted or written.
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data = $urandom;
            in_last = 1'b0;
            check_eq("post_ready_low", 64'(rdy[s]), 64'd0);
            check_eq("post_no_strobe", 64'(stb[s]), 64'd0);
            check_eq("error_sticky", 64'(err[s]), 64'(exp_err));
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic fill_random(input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back($urandom);
    endtask

    initial begin
        int n_stb, n_dn;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; sel = 0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check_eq("rst_flags", 64'({rdy[s], stb[s], halt[s], bsy[s], dn[s], err[s]}), 64'd0);
            check_eq("rst_addr", 64'(addr[s]), (s == 1) ? 64'd510 : 64'd0);
            check_eq("rst_data", 64'({d1[s], d2[s]}), 64'd0);
            check_eq("rst_wc", 64'(wc[s]), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        fill_random(4);
        run_load(0, 1'b0);
        fill_random(3);
        run_load(0, 1'b0);
        fill_random(6);
        run_load(1, 1'b0);
        fill_random(2);
        run_load(1, 1'b0);
        fill_random(4);
        run_load(0, 1'b1);

        // Reset while waiting for the odd word of the first pair.
        sel = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = $urandom; in_last = 1'b0;
        @(negedge clk); in_valid = 1'b0;
        check_eq("in_get_hi_ready", 64'(rdy[0]), 64'd1);
        check_eq("in_get_hi_wc", 64'(wc[0]), 64'd1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check_eq("mid_rst_flags", 64'({rdy[0], stb[0], halt[0], bsy[0], dn[0], err[0]}), 64'd0);
        check_eq("mid_rst_state", 64'({addr[0], wc[0]}), 64'd0);
        check_eq("mid_rst_data", 64'({d1[0], d2[0]}), 64'd0);
        n_stb = 0; n_dn = 0;
        repeat (4) begin
            @(negedge clk);
            n_stb += int'(stb[0]);
            n_dn += int'(dn[0]);
        end
        check_eq("mid_rst_no_strobe_done", 64'(n_stb + n_dn), 64'd0);
        fill_random(5);
        run_load(0, 1'b0);

        stim.delete();
        stim.push_back(32'd1); stim.push_back(32'd2); stim.push_back(32'd3);
        run_load(0, 1'b0);
        stim.delete();
        stim.push_back(32'd5);
        run_load(0, 1'b0);

        for (int it = 0; it < 8; it++) begin
            int s;
            s = int'($urandom_range(0, 1));
            fill_random((s == 1) ? int'($urandom_range(1, 8)) : int'($urandom_range(1, 12)));
            run_load(s, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
